// File: rtl/lockin_pkg.sv
// Shared widths and word-select encodings for the lock-in result capture path.
package lockin_pkg;
    localparam int RES_W  = 64;
    localparam int WORD_W = 32;
    localparam int PAIR_W = 2 * RES_W;

    localparam logic [1:0] SEL_FASE_LO = 2'd0;
    localparam logic [1:0] SEL_FASE_HI = 2'd1;
    localparam logic [1:0] SEL_CUAD_LO = 2'd2;
    localparam logic [1:0] SEL_CUAD_HI = 2'd3;

    // A stored pair is {cuad, fase}; fase occupies the low half.
    function automatic logic [WORD_W-1:0] pair_word(input logic [PAIR_W-1:0] pair,
                                                    input logic [1:0] sel);
        logic [WORD_W-1:0] w;
        w = '0;
        case (sel)
            SEL_FASE_LO: w = pair[WORD_W-1:0];
            SEL_FASE_HI: w = pair[RES_W-1:WORD_W];
            SEL_CUAD_LO: w = pair[RES_W+WORD_W-1:RES_W];
            SEL_CUAD_HI: w = pair[PAIR_W-1:RES_W+WORD_W];
            default:     w = '0;
        endcase
        return w;
    endfunction
endpackage

// File: rtl/result_pair_fifo.sv
// 128-bit synchronous FIFO for fase/cuad pairs; RAM array with a registered read port.
module result_pair_fifo
    import lockin_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [PAIR_W-1:0] din,
    output logic [PAIR_W-1:0] dout,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [PAIR_W-1:0] r_mem [DEPTH];
    logic [PAIR_W-1:0] r_dout;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic              r_empty;

    logic              w_push;
    logic              w_pop;
    logic [AW:0]       w_count_nxt;

    // A push into a full FIFO is only taken when a pop frees the head slot.
    assign w_pop  = pop & ~r_empty;
    assign w_push = push & (~r_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= din;
    end

    // Read-during-write at the same address (full push+pop) returns the old head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_dout <= '0;
        else if (w_pop)
            r_dout <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign dout  = r_dout;
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;
endmodule

// File: rtl/lockin_result_capture.sv
// Pairs lock-in fase/cuad results into a FIFO and exposes them as 32-bit words
// with fill, overflow, pairing-error and end-of-run status.
module lockin_result_capture
    import lockin_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [RES_W-1:0]  fase_in,
    input  logic              fase_valid,
    input  logic [RES_W-1:0]  cuad_in,
    input  logic              cuad_valid,
    input  logic              processing_finished,
    input  logic              rd_en,
    input  logic [1:0]        rd_word_sel,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW:0]       fill_count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              pair_error,
    output logic              run_done
);
    logic [RES_W-1:0]  r_fase_hold;
    logic [RES_W-1:0]  r_cuad_hold;
    logic              r_fase_pend;
    logic              r_cuad_pend;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_pair_error;
    logic              r_run_done;

    logic              w_fase_stb;
    logic              w_cuad_stb;
    logic              w_pair_rdy;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_pair_err;
    logic [PAIR_W-1:0] w_dout;
    logic [AW:0]       w_count;
    logic              w_full;
    logic              w_empty;

    assign w_fase_stb = fase_valid & enable & ~clear;
    assign w_cuad_stb = cuad_valid & enable & ~clear;
    assign w_pair_rdy = r_fase_pend & r_cuad_pend;
    assign w_push     = w_pair_rdy & ~clear;
    assign w_pop      = rd_en & ~w_empty & ~clear;
    assign w_drop     = w_push & w_full & ~w_pop;
    // A repeat half is only an error while its partner is still missing.
    assign w_pair_err = (w_fase_stb & r_fase_pend & ~r_cuad_pend) |
                        (w_cuad_stb & r_cuad_pend & ~r_fase_pend);

    result_pair_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .push    (w_push),
        .pop     (w_pop),
        .din     ({r_cuad_hold, r_fase_hold}),
        .dout    (w_dout),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fase_hold  <= '0;
            r_cuad_hold  <= '0;
            r_fase_pend  <= 1'b0;
            r_cuad_pend  <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_overflow   <= 1'b0;
            r_pair_error <= 1'b0;
            r_run_done   <= 1'b0;
        end else if (clear) begin
            r_fase_hold  <= '0;
            r_cuad_hold  <= '0;
            r_fase_pend  <= 1'b0;
            r_cuad_pend  <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_overflow   <= 1'b0;
            r_pair_error <= 1'b0;
            r_run_done   <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            // A strobe landing in the push cycle opens the next pair.
            if (w_fase_stb) begin
                r_fase_hold <= fase_in;
                r_fase_pend <= 1'b1;
            end else if (w_pair_rdy) begin
                r_fase_pend <= 1'b0;
            end
            if (w_cuad_stb) begin
                r_cuad_hold <= cuad_in;
                r_cuad_pend <= 1'b1;
            end else if (w_pair_rdy) begin
                r_cuad_pend <= 1'b0;
            end
            if (w_pair_err) r_pair_error <= 1'b1;
            if (w_drop)     r_overflow   <= 1'b1;
            if (processing_finished && !r_fase_pend && !r_cuad_pend)
                r_run_done <= 1'b1;
        end
    end

    assign rd_data    = pair_word(w_dout, rd_word_sel);
    assign rd_valid   = r_rd_valid;
    assign fill_count = w_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign pair_error = r_pair_error;
    assign run_done   = r_run_done;
endmodule

// File: tb/tb_lockin_result_capture.sv
// Randomized and directed checks of lockin_result_capture against a queue-based pair model.
module tb_lockin_result_capture;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        clear = 1'b0;
    logic [63:0] fase_in = '0;
    logic        fase_valid = 1'b0;
    logic [63:0] cuad_in = '0;
    logic        cuad_valid = 1'b0;
    logic        processing_finished = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_word_sel = 2'd0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [AW:0] fill_count;
    logic        empty, full, overflow, pair_error, run_done;

    int total = 0;
    int bad   = 0;

    // Behavioural model: completed pairs queue plus pending halves.
    logic [127:0] mq[$];
    bit           m_fp, m_cp, m_ovf, m_perr;
    logic [63:0]  m_fh, m_ch;

    lockin_result_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .fase_in(fase_in), .fase_valid(fase_valid), .cuad_in(cuad_in), .cuad_valid(cuad_valid),
        .processing_finished(processing_finished), .rd_en(rd_en), .rd_word_sel(rd_word_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .fill_count(fill_count), .empty(empty),
        .full(full), .overflow(overflow), .pair_error(pair_error), .run_done(run_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fp = 0; m_cp = 0; m_ovf = 0; m_perr = 0; m_fh = '0; m_ch = '0;
    endtask

    task automatic drive(input bit fv, input logic [63:0] f, input bit cv, input logic [63:0] c);
        fase_valid = fv; fase_in = f; cuad_valid = cv; cuad_in = c;
        tick();
        fase_valid = 0; cuad_valid = 0;
    endtask

    task automatic strobe(input bit fv, input logic [63:0] f, input bit cv, input logic [63:0] c);
        if ((fv && m_fp && !m_cp) || (cv && m_cp && !m_fp)) m_perr = 1;
        if (fv) begin m_fh = f; m_fp = 1; end
        if (cv) begin m_ch = c; m_cp = 1; end
        if (m_fp && m_cp) begin
            if (mq.size() < DEPTH) mq.push_back({m_ch, m_fh});
            else m_ovf = 1;
            m_fp = 0; m_cp = 0;
        end
        drive(fv, f, cv, c);
    endtask

    task automatic do_pop(output logic [127:0] got, output logic vld);
        rd_en = 1;
        tick();
        rd_en = 0;
        vld = rd_valid;
        for (int s = 0; s < 4; s++) begin
            rd_word_sel = 2'(s);
            #1;
            got[s*32 +: 32] = rd_data;
        end
        rd_word_sel = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
        model_reset();
    endtask

    task automatic drain(input string name, input int n);
        logic [127:0] got, exp;
        logic vld;
        for (int i = 0; i < n; i++) begin
            do_pop(got, vld);
            exp = mq.pop_front();
            total++;
            if (got !== exp || vld !== 1'b1) begin
                bad++;
                $display("FAIL %s[%0d] got=%h vld=%b exp=%h", name, i, got, vld, exp);
            end
        end
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL %s_empty got=%b exp=1", name, empty); end
    endtask

    task automatic test_reset();
        total++;
        if ({empty, full, overflow, pair_error, run_done, rd_valid} !== 6'b100000 ||
            fill_count !== '0 || rd_data !== '0) begin
            bad++;
            $display("FAIL reset got e/f/o/p/r/v=%b fill=%0d data=%h exp=100000 0 0",
                     {empty, full, overflow, pair_error, run_done, rd_valid}, fill_count, rd_data);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_w [4];
        logic [63:0] neg2;
        neg2 = -64'sd2;
        exp_w[0] = 32'h1; exp_w[1] = 32'h0; exp_w[2] = 32'hFFFF_FFFE; exp_w[3] = 32'hFFFF_FFFF;
        strobe(1, 64'h1, 1, neg2);
        tick(3);
        total++;
        if (fill_count !== 1) begin bad++; $display("FAIL same_fill got=%0d exp=1", fill_count); end
        rd_en = 1;
        tick();
        rd_en = 0;
        total++;
        if (rd_valid !== 1'b1) begin bad++; $display("FAIL same_rdvalid got=%b exp=1", rd_valid); end
        for (int s = 0; s < 4; s++) begin
            rd_word_sel = 2'(s);
            #1;
            total++;
            if (rd_data !== exp_w[s]) begin
                bad++; $display("FAIL same_word%0d got=%h exp=%h", s, rd_data, exp_w[s]);
            end
        end
        rd_word_sel = 0;
        void'(mq.pop_front());
        tick();
        total++;
        if (rd_valid !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL same_pulse got vld=%b empty=%b exp vld=0 empty=1", rd_valid, empty);
        end
        // A pop on an empty FIFO must not pulse rd_valid.
        rd_en = 1;
        tick();
        rd_en = 0;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL empty_pop got=%b exp=0", rd_valid); end
    endtask

    task automatic test_gap();
        strobe(1, 64'h1234_5678_9ABC_DEF0, 0, '0);
        tick(3);
        strobe(0, '0, 1, 64'h8000_0000_0000_0001);
        tick(3);
        total++;
        if (fill_count !== 1 || pair_error !== 1'b0) begin
            bad++; $display("FAIL gap got fill=%0d perr=%b exp fill=1 perr=0", fill_count, pair_error);
        end
        drain("gap", 1);
    endtask

    task automatic test_pair_error();
        strobe(1, 64'd5, 0, '0);
        strobe(1, 64'd7, 0, '0);
        strobe(0, '0, 1, 64'd9);
        tick(3);
        total++;
        if (pair_error !== 1'b1 || fill_count !== 1) begin
            bad++; $display("FAIL perr got perr=%b fill=%0d exp perr=1 fill=1", pair_error, fill_count);
        end
        total++;
        if (mq[0] !== {64'd9, 64'd7}) begin bad++; $display("FAIL perr_model got=%h exp=(9,7)", mq[0]); end
        drain("perr", 1);
    endtask

    task automatic test_enable();
        strobe(1, 64'hAA, 0, '0);
        enable = 0;
        drive(0, '0, 1, 64'hBB);
        drive(1, 64'hCC, 1, 64'hDD);
        tick(3);
        total++;
        if (fill_count !== 0) begin bad++; $display("FAIL en_off got=%0d exp=0", fill_count); end
        enable = 1;
        strobe(0, '0, 1, 64'hEE);
        tick(3);
        total++;
        if (fill_count !== 1) begin bad++; $display("FAIL en_on got=%0d exp=1", fill_count); end
        drain("en", 1);
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i <= DEPTH; i++) strobe(1, {$urandom(), $urandom()}, 1, {$urandom(), $urandom()});
        tick(3);
        total++;
        if (full !== 1'b1 || fill_count !== (AW+1)'(DEPTH) || overflow !== 1'b1 || m_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf got full=%b fill=%0d ovf=%b exp 1 %0d 1", full, fill_count, overflow, DEPTH);
        end
        drain("ovf", DEPTH);
    endtask

    task automatic test_full_push_pop();
        logic [63:0] f, c;
        logic [127:0] got, exp;
        logic vld;
        do_clear();
        for (int i = 0; i < DEPTH; i++) strobe(1, {$urandom(), $urandom()}, 1, {$urandom(), $urandom()});
        tick(2);
        f = {$urandom(), $urandom()};
        c = {$urandom(), $urandom()};
        // Pair is held for one cycle, then pushed while the head is popped.
        drive(1, f, 1, c);
        do_pop(got, vld);
        exp = mq.pop_front();
        mq.push_back({c, f});
        total++;
        if (got !== exp || vld !== 1'b1) begin bad++; $display("FAIL fpp_head got=%h exp=%h", got, exp); end
        tick(2);
        total++;
        if (fill_count !== (AW+1)'(DEPTH) || overflow !== 1'b0 || full !== 1'b1) begin
            bad++; $display("FAIL fpp got fill=%0d ovf=%b full=%b exp %0d 0 1", fill_count, overflow, full, DEPTH);
        end
        drain("fpp", DEPTH);
    endtask

    task automatic test_run_done();
        do_clear();
        strobe(0, '0, 1, 64'h11);
        processing_finished = 1;
        tick(3);
        total++;
        if (run_done !== 1'b0) begin bad++; $display("FAIL rd_pend got=%b exp=0", run_done); end
        strobe(1, 64'h22, 0, '0);
        tick(3);
        total++;
        if (run_done !== 1'b1 || fill_count !== 1) begin
            bad++; $display("FAIL rd_done got=%b fill=%0d exp 1 1", run_done, fill_count);
        end
        strobe(1, 64'h33, 0, '0);
        strobe(1, 64'h44, 0, '0);
        tick(2);
        processing_finished = 0;
        do_clear();
        total++;
        if ({run_done, overflow, pair_error, empty} !== 4'b0001 || fill_count !== 0) begin
            bad++;
            $display("FAIL clear got rd/ovf/perr/empty=%b fill=%0d exp 0001 0",
                     {run_done, overflow, pair_error, empty}, fill_count);
        end
    endtask

    task automatic test_random();
        bit fv, cv;
        do_clear();
        for (int i = 0; i < 60; i++) begin
            fv = ($urandom_range(0, 2) == 0);
            cv = ($urandom_range(0, 2) == 0);
            strobe(fv, {$urandom(), $urandom()}, cv, {$urandom(), $urandom()});
        end
        tick(3);
        total++;
        if (fill_count !== (AW+1)'(mq.size()) || pair_error !== m_perr || overflow !== m_ovf) begin
            bad++;
            $display("FAIL rand got fill=%0d perr=%b ovf=%b exp %0d %b %b",
                     fill_count, pair_error, overflow, mq.size(), m_perr, m_ovf);
        end
        drain("rand", mq.size());
    endtask

    task automatic test_reset_mid();
        do_clear();
        for (int i = 0; i < 5; i++) strobe(1, {$urandom(), $urandom()}, 1, {$urandom(), $urandom()});
        strobe(1, 64'h5, 0, '0);
        strobe(1, 64'h6, 0, '0);
        rd_en = 1;
        tick();
        fase_valid = 1; cuad_valid = 1;
        #2;
        reset_n = 0;
        #1;
        total++;
        if ({empty, full, overflow, pair_error, run_done, rd_valid} !== 6'b100000 ||
            fill_count !== '0 || rd_data !== '0) begin
            bad++;
            $display("FAIL reset_mid got e/f/o/p/r/v=%b fill=%0d data=%h exp=100000 0 0",
                     {empty, full, overflow, pair_error, run_done, rd_valid}, fill_count, rd_data);
        end
        fase_valid = 0; cuad_valid = 0; rd_en = 0;
        model_reset();
        tick(2);
        reset_n = 1;
        tick(2);
        total++;
        if (fill_count !== 0 || empty !== 1'b1) begin
            bad++; $display("FAIL post_reset got fill=%0d empty=%b exp 0 1", fill_count, empty);
        end
    endtask

    initial begin
        model_reset();
        tick(3);
        test_reset();
        reset_n = 1;
        tick(2);
        test_same_cycle();
        test_gap();
        test_pair_error();
        test_enable();
        test_overflow();
        test_full_push_pop();
        test_run_done();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
